// File: rtl/control_f_mc.sv
// control_f_mc: multi-channel filter-load controller.
// Accepts FILTER_N coefficients per channel for NUM_CH channels over a
// valid/ready handshake and drives the address, the one-hot channel write
// enable and the per-channel / global completion flags.
// Optional feature: define CONTROL_F_RELOAD_EN to let reload_f in DONE
// restart the whole load sequence.
module control_f_mc #(
  parameter int FILTER_N    = 8,
  parameter int LG_FILTER_N = 3,
  parameter int NUM_CH      = 4,
  parameter int LG_NUM_CH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid_f,
  output logic                   s_ready_f,
  input  logic                   mem_wr_state,
  input  logic                   reload_f,
  output logic [LG_FILTER_N-1:0] addr_f,
  output logic [LG_NUM_CH-1:0]   ch_f,
  output logic [NUM_CH-1:0]      wr_en_f,
  output logic [NUM_CH-1:0]      ch_done_f,
  output logic                   done_f
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [LG_FILTER_N-1:0] ADDR_LAST = LG_FILTER_N'(FILTER_N - 1);
  localparam logic [LG_NUM_CH-1:0]   CH_LAST   = LG_NUM_CH'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0]      CH_ONE    = NUM_CH'(1);

  state_t state, state_nxt;
  logic   accept;
  logic   last_addr;
  logic   last_ch;
  logic   reload_go;

`ifdef CONTROL_F_RELOAD_EN
  assign reload_go = (state == DONE) & reload_f;
`else
  logic unused_reload;
  assign unused_reload = reload_f;
  assign reload_go     = 1'b0;
`endif

  // Handshake, write enable and next-state decode.
  // Ready is masked by reset so nothing is accepted in a reset cycle.
  always_comb begin
    state_nxt = state;
    s_ready_f = (state == LOAD) & mem_wr_state & ~reset;
    accept    = s_valid_f & s_ready_f;
    last_addr = (addr_f == ADDR_LAST);
    last_ch   = (ch_f == CH_LAST);
    wr_en_f   = accept ? (CH_ONE << ch_f) : '0;
    case (state)
      IDLE:    if (mem_wr_state) state_nxt = LOAD;
      LOAD:    if (accept && last_addr && last_ch) state_nxt = DONE;
      DONE:    if (reload_go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Address / channel counters and completion flags, advanced on accept.
  always_ff @(posedge clk) begin
    if (reset || reload_go) begin
      addr_f    <= '0;
      ch_f      <= '0;
      ch_done_f <= '0;
      done_f    <= 1'b0;
    end else if (accept) begin
      if (last_addr) begin
        addr_f          <= '0;
        ch_done_f[ch_f] <= 1'b1;
        if (last_ch) begin
          ch_f   <= '0;
          done_f <= 1'b1;
        end else begin
          ch_f <= ch_f + 1'b1;
        end
      end else begin
        addr_f <= addr_f + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_f_mc.sv
// tb_control_f_mc: directed bench for control_f_mc with three instances
// (default 8x4, 5x3, and single-channel 8x1). Inputs change on the falling
// edge; outputs are sampled 1 ns later.
module tb_control_f_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // default instance: FILTER_N=8, NUM_CH=4
  logic       v0, m0, r0, rdy0, dn0;
  logic [2:0] a0;
  logic [1:0] c0;
  logic [3:0] w0, cd0;

  // FILTER_N=5, NUM_CH=3
  logic       v1, m1, rdy1, dn1;
  logic [2:0] a1, w1, cd1;
  logic [1:0] c1;

  // FILTER_N=8, NUM_CH=1
  logic       v2, m2, rdy2, dn2;
  logic [2:0] a2;
  logic [0:0] c2, w2, cd2;

  logic rz = 1'b0;

  control_f_mc u_d0 (
    .clk(clk), .reset(reset), .s_valid_f(v0), .s_ready_f(rdy0),
    .mem_wr_state(m0), .reload_f(r0), .addr_f(a0), .ch_f(c0),
    .wr_en_f(w0), .ch_done_f(cd0), .done_f(dn0));

  control_f_mc #(.FILTER_N(5), .LG_FILTER_N(3), .NUM_CH(3), .LG_NUM_CH(2)) u_d1 (
    .clk(clk), .reset(reset), .s_valid_f(v1), .s_ready_f(rdy1),
    .mem_wr_state(m1), .reload_f(rz), .addr_f(a1), .ch_f(c1),
    .wr_en_f(w1), .ch_done_f(cd1), .done_f(dn1));

  control_f_mc #(.FILTER_N(8), .LG_FILTER_N(3), .NUM_CH(1), .LG_NUM_CH(1)) u_d2 (
    .clk(clk), .reset(reset), .s_valid_f(v2), .s_ready_f(rdy2),
    .mem_wr_state(m2), .reload_f(rz), .addr_f(a2), .ch_f(c2),
    .wr_en_f(w2), .ch_done_f(cd2), .done_f(dn2));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v0 = 0; m0 = 0; r0 = 0;
    v1 = 0; m1 = 0; v2 = 0; m2 = 0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_addr",  a0,   0);
    check("rst_ch",    c0,   0);
    check("rst_wr",    w0,   0);
    check("rst_chd",   cd0,  0);
    check("rst_done",  dn0,  0);
    check("rst_ready", rdy0, 0);
  endtask

  // Continuous 32-word load on the default instance, starting in IDLE.
  // reload_f is pulsed during accepts 10..12; it must have no effect there.
  task automatic full_load(input string tag);
    m0 = 1; v0 = 1;
    #1;
    check({tag, "_idle_ready"}, rdy0, 0);
    check({tag, "_idle_wr"},    w0,   0);
    step();
    for (int k = 0; k < 32; k++) begin
      r0 = (k >= 10 && k <= 12);
      #1;
      check({tag, "_ready"}, rdy0, 1);
      check({tag, "_wr"},    w0,   1 << (k / 8));
      check({tag, "_addr"},  a0,   k % 8);
      check({tag, "_ch"},    c0,   k / 8);
      check({tag, "_chd"},   cd0,  (1 << (k / 8)) - 1);
      check({tag, "_done"},  dn0,  0);
      step();
    end
    r0 = 0;
    #1;
    check({tag, "_fin_done"},  dn0,  1);
    check({tag, "_fin_chd"},   cd0,  15);
    check({tag, "_fin_ready"}, rdy0, 0);
    check({tag, "_fin_wr"},    w0,   0);
    step();
    #1;
    check({tag, "_post_ready"}, rdy0, 0);
    check({tag, "_post_done"},  dn0,  1);
  endtask

  bit [31:0] seen;
  int        cnt;
  bit        dropped;

  initial begin
    reset = 1'b1;
    r0 = 0; v0 = 0; m0 = 0; v1 = 0; m1 = 0; v2 = 0; m2 = 0;
    step();

    // 1: continuous load on the default instance, then reload_f in DONE
    do_reset();
    full_load("cont");
    r0 = 1;
    step();
    r0 = 0;
    #1;
`ifdef CONTROL_F_RELOAD_EN
    check("reload_done", dn0,  0);
    check("reload_chd",  cd0,  0);
    check("reload_addr", a0,   0);
    check("reload_ch",   c0,   0);
    full_load("reload");
`else
    check("noreload_done",  dn0,  1);
    check("noreload_chd",   cd0,  15);
    check("noreload_ready", rdy0, 0);
`endif

    // 2: random valid, mem_wr_state dropped for 4 cycles inside channel 2
    do_reset();
    m0 = 1; seen = '0; cnt = 0; dropped = 0;
    for (int cyc = 0; cyc < 400 && cnt < 32; cyc++) begin
      if (cnt == 19 && !dropped) begin
        m0 = 0; v0 = 1;
        for (int j = 0; j < 4; j++) begin
          #1;
          check("pause_ready", rdy0, 0);
          check("pause_wr",    w0,   0);
          check("pause_addr",  a0,   3);
          check("pause_ch",    c0,   2);
          step();
        end
        m0 = 1; dropped = 1;
      end
      v0 = 1'($urandom_range(0, 1));
      #1;
      check("rnd_ready", rdy0, (cyc > 0) ? 1 : 0);
      if (v0 && cyc > 0) begin
        check("rnd_wr",   w0, 1 << (cnt / 8));
        check("rnd_addr", a0, cnt % 8);
        check("rnd_ch",   c0, cnt / 8);
        check("rnd_dup",  seen[cnt], 0);
        seen[cnt] = 1'b1;
        cnt++;
      end else begin
        check("rnd_idle_wr", w0, 0);
      end
      step();
    end
    #1;
    check("rnd_count", cnt, 32);
    check("rnd_all",   seen, 32'hFFFF_FFFF);
    check("rnd_done",  dn0, 1);
    v0 = 0;

    // 3: reset after 13 accepts, then a full reload
    do_reset();
    m0 = 1; v0 = 1;
    step();
    for (int k = 0; k < 13; k++) step();
    #1;
    check("mid_addr", a0, 5);
    check("mid_ch",   c0, 1);
    reset = 1;
    #1;
    check("mid_rst_wr", w0, 0);
    step();
    reset = 0;
    #1;
    check("mid_post_addr",  a0,   0);
    check("mid_post_ch",    c0,   0);
    check("mid_post_chd",   cd0,  0);
    check("mid_post_done",  dn0,  0);
    check("mid_post_ready", rdy0, 0);
    check("mid_post_wr",    w0,   0);
    full_load("after_rst");

    // 4: 5x3 and 8x1 instances in parallel, continuous valid
    do_reset();
    m1 = 1; v1 = 1; m2 = 1; v2 = 1;
    step();
    for (int k = 0; k < 15; k++) begin
      #1;
      check("n5_addr", a1,  k % 5);
      check("n5_ch",   c1,  k / 5);
      check("n5_wr",   w1,  1 << (k / 5));
      check("n5_chd",  cd1, (1 << (k / 5)) - 1);
      check("n5_done", dn1, 0);
      if (k < 8) begin
        check("c1_addr", a2,  k);
        check("c1_ch",   c2,  0);
        check("c1_wr",   w2,  1);
        check("c1_done", dn2, 0);
      end else begin
        check("c1_done_hi", dn2,  1);
        check("c1_ready",   rdy2, 0);
        check("c1_wr_off",  w2,   0);
        check("c1_chd",     cd2,  1);
        check("c1_ch_end",  c2,   0);
      end
      step();
    end
    #1;
    check("n5_fin_done",  dn1,  1);
    check("n5_fin_chd",   cd1,  7);
    check("n5_fin_ready", rdy1, 0);
    check("n5_fin_addr",  a1,   0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule

// File: doc/control_f_mc.md
# control_f_mc

Multi-channel filter-load controller for the 1-D convolution datapath, and the parametrised successor of the single-filter F-vector loader. It accepts a stream of filter coefficients over a valid/ready handshake and writes them into NUM_CH per-channel filter memories, FILTER_N words each. It generates the address, a one-hot channel write enable and per-channel completion flags. It raises `done_f` once every channel is loaded. It sits between the F-input port and the filter memory bank, gated by the top-level memory-write phase.

## Interface
- `FILTER_N`, 8: coefficients per channel; any value ≥ 2, need not be a power of two.
- `LG_FILTER_N`, 3: address width, = ceil(log2(FILTER_N)).
- `NUM_CH`, 4: number of filter channels, ≥ 1.
- `LG_NUM_CH`, 2: channel index width, = max(1, ceil(log2(NUM_CH))).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid_f`  in  1  coefficient word available on the F input.
- `s_ready_f`  out  1  block accepts a word this cycle.
- `mem_wr_state`  in  1  top-level memory-write phase active.
- `reload_f`  in  1  request to reload all filters; honoured only with `CONTROL_F_RELOAD_EN`.
- `addr_f`  out  LG_FILTER_N  write address within the current channel memory.
- `ch_f`  out  LG_NUM_CH  current channel index.
- `wr_en_f`  out  NUM_CH  one-hot write enable, bit `ch_f`.
- `ch_done_f`  out  NUM_CH  sticky per-channel "fully loaded" flags.
- `done_f`  out  1  all channels loaded (registered).

## Operation
- The FSM has three states: IDLE, LOAD and DONE. Reset enters IDLE.
- IDLE → LOAD on the first cycle `mem_wr_state`=1.
- In LOAD, `s_ready_f` = `mem_wr_state`. In IDLE and DONE it is 0.
- An accept happens when `s_valid_f & s_ready_f`.
  - `wr_en_f` = accept ? (1 << `ch_f`) : 0. This is combinational, in the same cycle.
  - Each accept increments `addr_f`.
- End of channel: an accept with `addr_f`=FILTER_N-1.
  - `addr_f` wraps to 0.
  - `ch_done_f[ch_f]` is set.
  - `ch_f` increments.
- Last channel: an accept with `ch_f`=NUM_CH-1 and `addr_f`=FILTER_N-1.
  - `ch_f` wraps to 0 and the FSM moves to DONE.
- `addr_f` wraps at FILTER_N-1, never at 2^LG_FILTER_N-1. No address ≥ FILTER_N is ever driven.
- With NUM_CH=1, `ch_f` is constantly 0.
- If `mem_wr_state` drops in LOAD, the block pauses. `s_ready_f`=0, all counters hold, the FSM stays in LOAD, and it resumes when `mem_wr_state` returns.
- `s_valid_f` may toggle freely. Cycles without an accept change nothing.
- In DONE, `done_f`=1 and `ch_done_f` is all ones. Further `s_valid_f` is never accepted.
- All outputs and state reset to 0 or IDLE: `addr_f`, `ch_f`, `wr_en_f`, `ch_done_f`, `done_f` and `s_ready_f` are all 0.
- Reset asserted mid-LOAD discards partial progress.

## Timing
- The IDLE→LOAD transition costs one cycle: `mem_wr_state` rises at cycle t, so `s_ready_f`=1 from t+1.
- Accept-to-write latency is 0: `wr_en_f`, `addr_f` and `ch_f` are valid in the accept cycle. `addr_f` and `ch_f` update at the following edge.
- `ch_done_f[c]` rises the cycle after the last accept of channel c.
- `done_f` rises the cycle after the final accept.
- With continuous valid and `mem_wr_state` high from cycle 0:
  - accepts occur on cycles 1 … NUM_CH·FILTER_N;
  - `done_f`=1 from cycle NUM_CH·FILTER_N+1.
- Reset has priority over every other input in the same cycle.

## Configuration
- `CONTROL_F_RELOAD_EN` defined: `reload_f`=1 in DONE clears `addr_f`, `ch_f`, `ch_done_f` and `done_f` at the next edge, and the FSM returns to IDLE. A new load then starts when `mem_wr_state`=1.
  - `reload_f` in IDLE or LOAD is ignored.
  - If `reload_f` and `reset` are asserted together, reset wins; the result is identical.
- Not defined: `reload_f` is ignored everywhere. DONE is terminal until `reset`.

## Test plan
- Defaults, `mem_wr_state`=1 and `s_valid_f`=1 from cycle 0:
  - 32 accepts on cycles 1–32;
  - `wr_en_f` 0001 for addr 0–7, then 0010, 0100, 1000;
  - `done_f`=1 at cycle 33 and `s_ready_f`=0 after.
- FILTER_N=5, NUM_CH=3:
  - `addr_f` sequence 0,1,2,3,4,0 with no address 5–7;
  - `ch_done_f` goes 001 → 011 → 111;
  - `done_f` after 15 accepts.
- Random `s_valid_f` (50%) plus `mem_wr_state` dropped for 4 cycles mid-channel 2:
  - no accepts and no counter movement while low;
  - exactly 32 writes in total, each address/channel pair written once.
- `reset` pulsed after 13 accepts: all outputs 0 next cycle, then a full 32-word reload completes normally.
- With `CONTROL_F_RELOAD_EN`:
  - `reload_f` during LOAD is ignored;
  - in DONE, `reload_f` gives `done_f`=0 and `ch_done_f`=0 next cycle, and a second 32-word load completes.
  - Without the macro, `reload_f` in DONE leaves `done_f`=1.
- NUM_CH=1, FILTER_N=8: `ch_f` stays 0, `wr_en_f`=1 on each accept, and `done_f` rises after 8 accepts.
